// File: rtl/lcd_reader.sv
// ---------------------------------------------------------------------------
// lcd_reader
//   Read side of the HD44780 LCD custom instruction (Nios II multicycle).
//   Runs one LCD read cycle with RW=1, or a busy-poll sequence of status reads,
//   and returns the sampled byte. With RS=0 the byte is busy flag + address
//   counter. With RS=1 the byte is DDRAM/CGRAM data.
//
//   Optional feature macro: LCD_RD_TIMEOUT_EN
//     When defined, a poll aborts after TMO status reads that still show BF=1.
//     The abort sets result[31]. When undefined, a poll runs until BF=0.
//
// Ports
//   clk      system clock
//   reset    synchronous, active-high reset
//   clk_en   custom-instruction qualifier
//   start    start pulse, accepted only when clk_en=1 and the FSM is idle
//   dataa    [0] rs value, [1] poll mode (honoured only when [0]=0)
//   done     one-cycle pulse, result valid in the same cycle
//   result   [7:0] last byte, [30:16] read count (saturating), [31] timeout
//   rw       1 while a transaction is in progress (top level tristates db)
//   en       LCD enable
//   rs       LCD register select
//   db_in    LCD data bus, input side
// ---------------------------------------------------------------------------
module lcd_reader #(
  parameter int T_AS = 3,
  parameter int T_PW = 25,
  parameter int T_H  = 25,
  parameter int TMO  = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic        done,
  output logic [31:0] result,
  output logic        rw,
  output logic        en,
  output logic        rs,
  input  logic [7:0]  db_in
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_EN_HI = 3'd2,
    S_EN_LO = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Each timed state loads (duration - 1) and leaves when the timer reads 0.
  localparam logic [15:0] L_AS = 16'(T_AS - 1);
  localparam logic [15:0] L_PW = 16'(T_PW - 1);
  localparam logic [15:0] L_H  = 16'(T_H - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_tmr;
  logic        w_load;
  logic [15:0] w_load_val;
  logic        w_accept;
  logic        w_timeout;
  logic        w_sample;
  logic        w_active;

  logic        r_rs_sel;
  logic        r_poll;
  logic [7:0]  r_byte;
  logic [14:0] r_cnt;
  logic        r_to;
  logic        r_en;
  logic        r_rw;
  logic        r_rs;
  logic        r_done;
  logic [31:0] r_result;
`ifdef LCD_RD_TIMEOUT_EN
  logic [31:0] r_poll_cnt;
`endif

  logic w_unused;
  assign w_unused = ^dataa[31:2];

  assign w_accept = start & clk_en & (r_state == S_IDLE);
  assign w_active = (r_state == S_SETUP) | (r_state == S_EN_HI) | (r_state == S_EN_LO);
  // en is registered from EN_HI, so the first EN_LO edge is the one that drops en.
  assign w_sample = (r_state == S_EN_LO) & r_en;

  // Next-state logic and phase timer reload requests
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = 16'd0;
    w_timeout  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next     = S_SETUP;
          w_load     = 1'b1;
          w_load_val = L_AS;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_SETUP: begin
        if (r_tmr == 16'd0) begin
          w_next     = S_EN_HI;
          w_load     = 1'b1;
          w_load_val = L_PW;
        end else begin
          w_next = S_SETUP;
        end
      end
      S_EN_HI: begin
        if (r_tmr == 16'd0) begin
          w_next     = S_EN_LO;
          w_load     = 1'b1;
          w_load_val = L_H;
        end else begin
          w_next = S_EN_HI;
        end
      end
      S_EN_LO: begin
        if (r_tmr != 16'd0) begin
          w_next = S_EN_LO;
        end else if (r_poll && r_byte[7]) begin
`ifdef LCD_RD_TIMEOUT_EN
          if (r_poll_cnt >= 32'(TMO)) begin
            w_next    = S_DONE;
            w_timeout = 1'b1;
          end else begin
            w_next     = S_SETUP;
            w_load     = 1'b1;
            w_load_val = L_AS;
          end
`else
          w_next     = S_SETUP;
          w_load     = 1'b1;
          w_load_val = L_AS;
`endif
        end else begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register and phase timer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_tmr   <= 16'd0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_tmr <= w_load_val;
      end else if (r_tmr != 16'd0) begin
        r_tmr <= r_tmr - 16'd1;
      end
    end
  end

  // LCD pins, sampled byte, read counters and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rs_sel <= 1'b0;
      r_poll   <= 1'b0;
      r_byte   <= 8'h00;
      r_cnt    <= 15'd0;
      r_to     <= 1'b0;
      r_en     <= 1'b0;
      r_rw     <= 1'b0;
      r_rs     <= 1'b0;
      r_done   <= 1'b0;
      r_result <= 32'd0;
`ifdef LCD_RD_TIMEOUT_EN
      r_poll_cnt <= 32'd0;
`endif
    end else begin
      if (w_accept) begin
        r_rs_sel <= dataa[0];
        // A data read never polls: BF only exists in the status byte.
        r_poll   <= dataa[1] & ~dataa[0];
        r_cnt    <= 15'd0;
        r_to     <= 1'b0;
`ifdef LCD_RD_TIMEOUT_EN
        r_poll_cnt <= 32'd0;
`endif
      end
      r_rw <= w_active;
      r_en <= (r_state == S_EN_HI);
      // rs only moves in SETUP, where en is already low.
      if (r_state == S_SETUP) begin
        r_rs <= r_rs_sel;
      end
      if (w_sample) begin
        r_byte <= db_in;
        if (r_cnt != 15'h7FFF) begin
          r_cnt <= r_cnt + 15'd1;
        end
`ifdef LCD_RD_TIMEOUT_EN
        r_poll_cnt <= r_poll_cnt + 32'd1;
`endif
      end
      if (w_timeout) begin
        r_to <= 1'b1;
      end
      r_done <= (r_state == S_DONE);
      if (r_state == S_DONE) begin
        r_result <= {r_to, r_cnt, 8'h00, r_byte};
      end
    end
  end

  assign done   = r_done;
  assign result = r_result;
  assign rw     = r_rw;
  assign en     = r_en;
  assign rs     = r_rs;

endmodule
